// File: rtl/dot11_rx_ctrl_pkg.sv
// Shared encodings for the dot11 receive packet sequencer.
// Pure declarations: no latency.
// No flow control; constants only.
package dot11_rx_ctrl_pkg;

  typedef enum logic [3:0] {
    S_CONFIG     = 4'd0,
    S_WAIT_POWER = 4'd1,
    S_WAIT_LONG  = 4'd2,
    S_WAIT_SIG   = 4'd3,
    S_CHECK      = 4'd4,
    S_RX_DATA    = 4'd5,
    S_FLUSH      = 4'd6
  } rx_state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LONG_TO = 3'd1;
  localparam logic [2:0] ERR_SIG_TO  = 3'd2;
  localparam logic [2:0] ERR_PARITY  = 3'd3;
  localparam logic [2:0] ERR_RATE    = 3'd4;
  localparam logic [2:0] ERR_RSVD    = 3'd5;
  localparam logic [2:0] ERR_LEN     = 3'd6;
  localparam logic [2:0] ERR_DATA_TO = 3'd7;

  // Setting-bus address of the receiver skip-sample register
  localparam logic [7:0] SR_SKIP_SAMPLE = 8'd1;

endpackage

// File: rtl/dot11_sig_check.sv
// Validates the legacy SIGNAL field and reports the first failing check.
// Combinational, zero latency.
// No flow control; result is valid whenever its inputs are.
module dot11_sig_check
  import dot11_rx_ctrl_pkg::*;
(
  input  logic [3:0]  rate,
  input  logic        rsvd,
  input  logic [11:0] len,
  input  logic        parity,
  input  logic [5:0]  tail,
  output logic        ok,
  output logic [2:0]  err_code
);

  // Priority-ordered checks: parity, rate, reserved/tail, length
  always_comb begin
    ok       = 1'b0;
    err_code = ERR_NONE;
    if (^{rate, rsvd, len, parity}) begin
      err_code = ERR_PARITY;
    end else if (!rate[3]) begin
      err_code = ERR_RATE;
    end else if (rsvd || (|tail)) begin
      err_code = ERR_RSVD;
    end else if (len == 12'd0) begin
      err_code = ERR_LEN;
    end else begin
      ok = 1'b1;
    end
  end

endmodule

// File: rtl/dot11_rx_ctrl.sv
// Packet sequencer: configures the receiver, tracks preamble/SIGNAL/DATA, flushes on end or error.
// Status pulses are combinational in the cycle of the causing event; the state register moves on the next edge.
// No backpressure; inputs outside the expected stage are ignored. Optional counters: DOT11_RX_STATS_EN.
module dot11_rx_ctrl
  import dot11_rx_ctrl_pkg::*;
#(
  parameter int TO_LONG      = 320,
  parameter int TO_SIG       = 240,
  parameter int TO_DATA      = 65535,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cfg_skip_sample,
  input  logic        cfg_update,
  input  logic        sample_in_strobe,
  input  logic        power_trigger,
  input  logic        short_preamble_detected,
  input  logic        long_preamble_detected,
  input  logic        legacy_sig_stb,
  input  logic [3:0]  legacy_rate,
  input  logic        legacy_sig_rsvd,
  input  logic [11:0] legacy_len,
  input  logic        legacy_sig_parity,
  input  logic [5:0]  legacy_sig_tail,
  input  logic        byte_out_strobe,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        rx_enable,
  output logic        rx_soft_reset,
  output logic        pkt_start,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic [11:0] byte_count,
  output logic [3:0]  state
`ifdef DOT11_RX_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err,
  output logic [15:0] stat_false
`endif
);

  rx_state_t   state_q, state_nxt;
  logic        rst_hold_q;
  logic [15:0] timer_q;
  logic        cfg_pend_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic [3:0]  rate_q;
  logic        rsvd_q, parity_q;
  logic [11:0] len_q, byte_count_q;
  logic [5:0]  tail_q;
  logic [2:0]  err_q, err_cause, sig_err;
  logic        sig_ok, false_alarm;

  dot11_sig_check u_sig_check (
    .rate     (rate_q),
    .rsvd     (rsvd_q),
    .len      (len_q),
    .parity   (parity_q),
    .tail     (tail_q),
    .ok       (sig_ok),
    .err_code (sig_err)
  );

  // Next-state and per-state outputs; real events beat timeouts, any error forces a flush
  always_comb begin
    state_nxt     = state_q;
    set_stb       = 1'b0;
    rx_enable     = 1'b0;
    rx_soft_reset = 1'b0;
    pkt_start     = 1'b0;
    pkt_done      = 1'b0;
    pkt_err       = 1'b0;
    err_cause     = ERR_NONE;
    false_alarm   = 1'b0;
    case (state_q)
      S_CONFIG: begin
        // First cycle out of reset keeps the receiver in reset before the write
        if (rst_hold_q) begin
          rx_soft_reset = 1'b1;
        end else begin
          set_stb   = 1'b1;
          state_nxt = S_WAIT_POWER;
        end
      end
      S_WAIT_POWER: begin
        rx_enable = 1'b1;
        if (cfg_pend_q)                                     state_nxt = S_CONFIG;
        else if (short_preamble_detected && power_trigger) state_nxt = S_WAIT_LONG;
      end
      S_WAIT_LONG: begin
        rx_enable = 1'b1;
        if (long_preamble_detected) begin
          state_nxt = S_WAIT_SIG;
        end else if (!power_trigger) begin
          false_alarm = 1'b1;
          state_nxt   = S_FLUSH;
        end else if (timer_q == 16'(TO_LONG)) begin
          pkt_err   = 1'b1;
          err_cause = ERR_LONG_TO;
        end
      end
      S_WAIT_SIG: begin
        rx_enable = 1'b1;
        if (legacy_sig_stb) begin
          state_nxt = S_CHECK;
        end else if (timer_q == 16'(TO_SIG)) begin
          pkt_err   = 1'b1;
          err_cause = ERR_SIG_TO;
        end
      end
      S_CHECK: begin
        rx_enable = 1'b1;
        if (sig_ok) begin
          pkt_start = 1'b1;
          state_nxt = S_RX_DATA;
        end else begin
          pkt_err   = 1'b1;
          err_cause = sig_err;
        end
      end
      S_RX_DATA: begin
        rx_enable = 1'b1;
        if (byte_out_strobe) begin
          if (byte_count_q + 12'd1 == len_q) begin
            pkt_done  = 1'b1;
            state_nxt = S_FLUSH;
          end
        end else if (timer_q == 16'(TO_DATA)) begin
          pkt_err   = 1'b1;
          err_cause = ERR_DATA_TO;
        end
      end
      S_FLUSH: begin
        rx_soft_reset = 1'b1;
        if (timer_q == 16'(FLUSH_CYCLES - 1)) state_nxt = S_WAIT_POWER;
      end
      default: state_nxt = S_CONFIG;
    endcase
    if (pkt_err) state_nxt = S_FLUSH;
  end

  assign set_addr   = set_stb ? SR_SKIP_SAMPLE : set_addr_q;
  assign set_data   = set_stb ? cfg_skip_sample : set_data_q;
  assign err_code   = pkt_err ? err_cause : (pkt_start ? ERR_NONE : err_q);
  assign byte_count = byte_count_q;
  assign state      = state_q;

  // State, stage timer, sticky config request, captured SIGNAL fields and packet status
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_CONFIG;
      rst_hold_q   <= 1'b1;
      timer_q      <= '0;
      cfg_pend_q   <= 1'b0;
      set_addr_q   <= '0;
      set_data_q   <= '0;
      rate_q       <= '0;
      rsvd_q       <= 1'b0;
      parity_q     <= 1'b0;
      len_q        <= '0;
      tail_q       <= '0;
      byte_count_q <= '0;
      err_q        <= ERR_NONE;
    end else begin
      state_q    <= state_nxt;
      rst_hold_q <= 1'b0;
      // Flush length is counted in clocks; other stages count sample strobes
      if (state_nxt != state_q)                            timer_q <= '0;
      else if (state_q == S_FLUSH)                         timer_q <= timer_q + 16'd1;
      else if (state_q == S_RX_DATA && byte_out_strobe)    timer_q <= '0;
      else if (sample_in_strobe)                           timer_q <= timer_q + 16'd1;
      if (state_nxt == S_CONFIG && state_q != S_CONFIG)    cfg_pend_q <= 1'b0;
      else if (cfg_update)                                 cfg_pend_q <= 1'b1;
      if (set_stb) begin
        set_addr_q <= SR_SKIP_SAMPLE;
        set_data_q <= cfg_skip_sample;
      end
      if (state_q == S_WAIT_SIG && legacy_sig_stb) begin
        rate_q       <= legacy_rate;
        rsvd_q       <= legacy_sig_rsvd;
        parity_q     <= legacy_sig_parity;
        len_q        <= legacy_len;
        tail_q       <= legacy_sig_tail;
        byte_count_q <= '0;
      end else if (state_q == S_RX_DATA && byte_out_strobe) begin
        byte_count_q <= byte_count_q + 12'd1;
      end
      if (pkt_err)        err_q <= err_cause;
      else if (pkt_start) err_q <= ERR_NONE;
    end
  end

`ifdef DOT11_RX_STATS_EN
  // Saturating packet outcome counters, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ok    <= '0;
      stat_err   <= '0;
      stat_false <= '0;
    end else begin
      if (pkt_done && stat_ok != 16'hFFFF)       stat_ok    <= stat_ok + 16'd1;
      if (pkt_err && stat_err != 16'hFFFF)       stat_err   <= stat_err + 16'd1;
      if (false_alarm && stat_false != 16'hFFFF) stat_false <= stat_false + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dot11_rx_ctrl.sv
// Directed bench for the dot11 receive packet sequencer.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
// Each task checks its own scenario against hand-computed values.
module tb_dot11_rx_ctrl;

  localparam logic [3:0] ST_CONFIG = 4'd0;
  localparam logic [3:0] ST_WAIT_POWER = 4'd1;
  localparam logic [3:0] ST_WAIT_LONG = 4'd2;
  localparam logic [3:0] ST_CHECK = 4'd4;
  localparam logic [3:0] ST_RX_DATA = 4'd5;
  localparam logic [3:0] ST_FLUSH = 4'd6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cfg_skip_sample = '0;
  logic        cfg_update = 1'b0;
  logic        sample_in_strobe = 1'b0;
  logic        power_trigger = 1'b0;
  logic        short_preamble_detected = 1'b0;
  logic        long_preamble_detected = 1'b0;
  logic        legacy_sig_stb = 1'b0;
  logic [3:0]  legacy_rate = '0;
  logic        legacy_sig_rsvd = 1'b0;
  logic [11:0] legacy_len = '0;
  logic        legacy_sig_parity = 1'b0;
  logic [5:0]  legacy_sig_tail = '0;
  logic        byte_out_strobe = 1'b0;
  logic        set_stb, rx_enable, rx_soft_reset, pkt_start, pkt_done, pkt_err;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [2:0]  err_code;
  logic [11:0] byte_count;
  logic [3:0]  state;
`ifdef DOT11_RX_STATS_EN
  logic [15:0] stat_ok, stat_err, stat_false;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dot11_rx_ctrl dut (
    .clock(clock), .reset(reset),
    .cfg_skip_sample(cfg_skip_sample), .cfg_update(cfg_update),
    .sample_in_strobe(sample_in_strobe), .power_trigger(power_trigger),
    .short_preamble_detected(short_preamble_detected),
    .long_preamble_detected(long_preamble_detected),
    .legacy_sig_stb(legacy_sig_stb), .legacy_rate(legacy_rate),
    .legacy_sig_rsvd(legacy_sig_rsvd), .legacy_len(legacy_len),
    .legacy_sig_parity(legacy_sig_parity), .legacy_sig_tail(legacy_sig_tail),
    .byte_out_strobe(byte_out_strobe),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rx_enable(rx_enable), .rx_soft_reset(rx_soft_reset),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_code(err_code), .byte_count(byte_count), .state(state)
`ifdef DOT11_RX_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err), .stat_false(stat_false)
`endif
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  // Wait (bounded) for the flush to finish and the sequencer to re-arm
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && state !== ST_WAIT_POWER; i++) cyc();
    n_checks++;
    if (state !== ST_WAIT_POWER) begin
      n_errors++;
      $display("FAIL %s_rearm: state=%0d required=%0d", tag, state, ST_WAIT_POWER);
    end
  endtask

  // Drive power trigger, both preambles and one SIGNAL; returns sampling the CHECK cycle
  task automatic send_sig(input logic [3:0] r, input logic rs, input logic [11:0] l, input logic p);
    power_trigger = 1'b1;
    short_preamble_detected = 1'b1;
    cyc();
    short_preamble_detected = 1'b0;
    long_preamble_detected = 1'b1;
    cyc();
    long_preamble_detected = 1'b0;
    legacy_rate = r;
    legacy_sig_rsvd = rs;
    legacy_len = l;
    legacy_sig_parity = p;
    legacy_sig_tail = 6'd0;
    legacy_sig_stb = 1'b1;
    cyc();
    legacy_sig_stb = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== ST_CONFIG || rx_soft_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d soft=%0d required 0/1", state, rx_soft_reset);
    end
    n_checks++;
    if ({set_stb, rx_enable, pkt_start, pkt_done, pkt_err, err_code, byte_count, set_addr, set_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: stb=%0d en=%0d st=%0d dn=%0d er=%0d code=%0d cnt=%0d addr=%0d data=%h required all 0",
               set_stb, rx_enable, pkt_start, pkt_done, pkt_err, err_code, byte_count, set_addr, set_data);
    end
    cyc();
    n_checks++;
    if (set_stb !== 1'b1 || set_addr !== 8'd1 || set_data !== 32'd0 || rx_soft_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL config_write: stb=%0d addr=%0d data=%h soft=%0d required 1/1/0/0", set_stb, set_addr, set_data, rx_soft_reset);
    end
    cyc();
    n_checks++;
    if (state !== ST_WAIT_POWER || rx_enable !== 1'b1 || set_stb !== 1'b0 || set_addr !== 8'd1) begin
      n_errors++;
      $display("FAIL config_done: state=%0d en=%0d stb=%0d addr=%0d required 1/1/0/1", state, rx_enable, set_stb, set_addr);
    end
  endtask

  // rate 1001, len 100 = 0x064: five ones in total, so parity 1 makes it even
  task automatic test_good_packet();
    int early, flush_n;
    send_sig(4'b1001, 1'b0, 12'd100, 1'b1);
    n_checks++;
    if (pkt_start !== 1'b1 || pkt_err !== 1'b0 || err_code !== 3'd0 || byte_count !== 12'd0) begin
      n_errors++;
      $display("FAIL good_start: start=%0d err=%0d code=%0d cnt=%0d required 1/0/0/0", pkt_start, pkt_err, err_code, byte_count);
    end
    cyc();
    early = 0;
    for (int i = 0; i < 100; i++) begin
      byte_out_strobe = 1'b1;
      #1;
      if (i < 99 && pkt_done === 1'b1) early++;
      if (i == 99) begin
        n_checks++;
        if (pkt_done !== 1'b1) begin
          n_errors++;
          $display("FAIL good_done_last: pkt_done=%0d required 1", pkt_done);
        end
      end
      cyc();
    end
    byte_out_strobe = 1'b0;
    n_checks++;
    if (early != 0) begin
      n_errors++;
      $display("FAIL good_done_early: early pulses=%0d required 0", early);
    end
    #1;
    n_checks++;
    if (state !== ST_FLUSH || byte_count !== 12'd100 || rx_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL good_after: state=%0d cnt=%0d en=%0d required 6/100/0", state, byte_count, rx_enable);
    end
    flush_n = 0;
    while (rx_soft_reset === 1'b1 && flush_n < 20) begin
      flush_n++;
      cyc();
    end
    n_checks++;
    if (flush_n != 8) begin
      n_errors++;
      $display("FAIL good_flush_len: cycles=%0d required 8", flush_n);
    end
    wait_idle("good");
  endtask

  task automatic test_sig_error(input string tag, input logic [3:0] r, input logic rs,
                                input logic [11:0] l, input logic p, input logic [2:0] exp_code);
    send_sig(r, rs, l, p);
    n_checks++;
    if (pkt_err !== 1'b1 || pkt_start !== 1'b0 || err_code !== exp_code) begin
      n_errors++;
      $display("FAIL %s: err=%0d start=%0d code=%0d required 1/0/%0d", tag, pkt_err, pkt_start, err_code, exp_code);
    end
    cyc();
    n_checks++;
    if (state !== ST_FLUSH || err_code !== exp_code) begin
      n_errors++;
      $display("FAIL %s_hold: state=%0d code=%0d required 6/%0d", tag, state, err_code, exp_code);
    end
    wait_idle(tag);
  endtask

  task automatic test_long_timeout();
    int seen;
    power_trigger = 1'b1;
    short_preamble_detected = 1'b1;
    cyc();
    short_preamble_detected = 1'b0;
    seen = 0;
    for (int i = 0; i < 319; i++) begin
      sample_in_strobe = 1'b1;
      #1;
      if (pkt_err === 1'b1) seen++;
      cyc();
    end
    sample_in_strobe = 1'b0;
    cyc();
    #1;
    n_checks++;
    if (seen != 0 || pkt_err !== 1'b0 || state !== ST_WAIT_LONG) begin
      n_errors++;
      $display("FAIL long_to_319: early_errs=%0d err=%0d state=%0d required 0/0/2", seen, pkt_err, state);
    end
    sample_in_strobe = 1'b1;
    cyc();
    sample_in_strobe = 1'b0;
    #1;
    n_checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd1) begin
      n_errors++;
      $display("FAIL long_to_320: err=%0d code=%0d required 1/1", pkt_err, err_code);
    end
    wait_idle("long_to");
  endtask

  task automatic test_false_alarm();
`ifdef DOT11_RX_STATS_EN
    logic [15:0] before;
    before = stat_false;
`endif
    power_trigger = 1'b1;
    short_preamble_detected = 1'b1;
    cyc();
    short_preamble_detected = 1'b0;
    power_trigger = 1'b0;
    #1;
    n_checks++;
    if (pkt_err !== 1'b0) begin
      n_errors++;
      $display("FAIL false_no_err: pkt_err=%0d required 0", pkt_err);
    end
    cyc();
    n_checks++;
    if (state !== ST_FLUSH || rx_soft_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL false_flush: state=%0d soft=%0d required 6/1", state, rx_soft_reset);
    end
`ifdef DOT11_RX_STATS_EN
    n_checks++;
    if (stat_false !== before + 16'd1) begin
      n_errors++;
      $display("FAIL false_stat: stat_false=%0d required %0d", stat_false, before + 16'd1);
    end
`endif
    wait_idle("false");
  endtask

  task automatic test_cfg_update();
    cfg_skip_sample = 32'hDEADBEEF;
    cfg_update = 1'b1;
    cyc();
    cfg_update = 1'b0;
    cyc();
    n_checks++;
    if (state !== ST_CONFIG || set_stb !== 1'b1 || set_addr !== 8'd1 || set_data !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL cfg_rewrite: state=%0d stb=%0d addr=%0d data=%h required 0/1/1/deadbeef", state, set_stb, set_addr, set_data);
    end
    cyc();
    n_checks++;
    if (state !== ST_WAIT_POWER || set_stb !== 1'b0 || set_data !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL cfg_hold: state=%0d stb=%0d data=%h required 1/0/deadbeef", state, set_stb, set_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    // Parity flipped on the valid SIGNAL
    test_sig_error("parity", 4'b1001, 1'b0, 12'd100, 1'b0, 3'd3);
    // rate 0011 + len 100: five ones, parity 1
    test_sig_error("rate", 4'b0011, 1'b0, 12'd100, 1'b1, 3'd4);
    // rsvd set: six ones, parity 0
    test_sig_error("rsvd", 4'b1001, 1'b1, 12'd100, 1'b0, 3'd5);
    // len 0: two ones, parity 0
    test_sig_error("len0", 4'b1001, 1'b0, 12'd0, 1'b0, 3'd6);
    test_long_timeout();
    test_false_alarm();
    test_cfg_update();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
